// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo.
// The flush input exists only when FIFO_FLUSH_EN is defined.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
`ifdef FIFO_FLUSH_EN
    logic                  flush;
`endif

    modport master (
`ifdef FIFO_FLUSH_EN
        output flush,
`endif
        output wr_en, rd_en, din,
        input  dout, data_count, wr_ack, wr_err, rd_ack, rd_err,
        input  full, empty, almost_full, almost_empty
    );

    modport slave (
`ifdef FIFO_FLUSH_EN
        input  flush,
`endif
        input  wr_en, rd_en, din,
        output dout, data_count, wr_ack, wr_err, rd_ack, rd_err,
        output full, empty, almost_full, almost_empty
    );
endinterface

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with same-cycle read/write and status flags.
// Optional synchronous flush is enabled by defining FIFO_FLUSH_EN.
module param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic        clk,
    input  logic        reset,
    param_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERR   = 3'b011,
        READ     = 3'b100,
        RD_ERR   = 3'b101,
        RDWR     = 3'b110,
        WR_RDERR = 3'b111
    } state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  is_full, is_empty;
    logic                  flush_req;
    logic                  do_write, do_read;

`ifdef FIFO_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    assign is_full  = (count == CNT_FULL);
    assign is_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= next_state;
    end

    // Flush wins over requests; RDWR is legal when full since the read frees a slot.
    always_comb begin
        next_state = NO_OP;
        if (!flush_req) begin
            unique case ({bus.wr_en, bus.rd_en})
                2'b10:   next_state = is_full  ? WR_ERR   : WRITE;
                2'b01:   next_state = is_empty ? RD_ERR   : READ;
                2'b11:   next_state = is_empty ? WR_RDERR : RDWR;
                default: next_state = NO_OP;
            endcase
        end
    end

    assign do_write = (next_state == WRITE) || (next_state == RDWR) || (next_state == WR_RDERR);
    assign do_read  = (next_state == READ)  || (next_state == RDWR);

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (!reset && do_write) mem[tail] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (flush_req) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_write) tail <= tail + PTR_ONE;
            if (do_read) begin
                rd_data <= mem[head];
                head    <= head + PTR_ONE;
            end
            unique case ({do_write, do_read})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign bus.dout         = rd_data;
    assign bus.data_count   = count;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = int'(count) >= AF_LEVEL;
    assign bus.almost_empty = int'(count) <= AE_LEVEL;

    assign bus.wr_ack = (state == WRITE) || (state == RDWR) || (state == WR_RDERR);
    assign bus.wr_err = (state == WR_ERR);
    assign bus.rd_ack = (state == READ)  || (state == RDWR);
    assign bus.rd_err = (state == RD_ERR) || (state == WR_RDERR);
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the stimulus.
module tb_param_fifo;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of stored words plus last-edge outcome bits.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
    bit            started = 0;

    always @(posedge clk) begin
        logic fl;
        fl = 1'b0;
`ifdef FIFO_FLUSH_EN
        fl = bus.flush;
`endif
        m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
        if (reset) begin
            q.delete();
            m_dout  = '0;
            started = 1;
        end else if (fl) begin
            q.delete();
        end else if (bus.wr_en && bus.rd_en) begin
            if (q.size() == 0) begin
                q.push_back(bus.din);
                m_wr_ack = 1; m_rd_err = 1;
            end else begin
                m_dout = q.pop_front();
                q.push_back(bus.din);
                m_wr_ack = 1; m_rd_ack = 1;
            end
        end else if (bus.wr_en) begin
            if (q.size() == DEPTH) m_wr_err = 1;
            else begin q.push_back(bus.din); m_wr_ack = 1; end
        end else if (bus.rd_en) begin
            if (q.size() == 0) m_rd_err = 1;
            else begin m_dout = q.pop_front(); m_rd_ack = 1; end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_dout",  bus.dout, m_dout);
            chk("model_count", bus.data_count, q.size());
            chk("model_flags",
                {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err,
                 bus.full, bus.empty, bus.almost_full, bus.almost_empty},
                {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err,
                 q.size() == DEPTH, q.size() == 0, q.size() >= DEPTH - 2, q.size() <= 2});
        end
    end

    // Apply one edge's worth of inputs; returns 1ns after that edge.
    task automatic drive(input logic rst, input logic fl, input logic w, input logic r,
                         input logic [DW-1:0] d);
        @(negedge clk);
        reset     = rst;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
`ifdef FIFO_FLUSH_EN
        bus.flush = fl;
`else
        if (fl) $display("flush ignored: feature not built");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        drive(1'b0, 1'b0, w, r, d);
    endtask

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.din = '0;
`ifdef FIFO_FLUSH_EN
        bus.flush = 0;
`endif
        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_count", bus.data_count, 0);
        chk("rst_flags", {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, 4'b0101);
        chk("rst_acks", {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 4'b0000);
        chk("rst_dout", bus.dout, 0);

        // Fill 0x11..0x20
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, DW'(32'h11 + i));
            chk("fill_ack", bus.wr_ack, 1);
            chk("fill_af", bus.almost_full, (i + 1) >= 14);
        end
        chk("fill_count", bus.data_count, 16);
        chk("fill_full", bus.full, 1);

        cyc(1'b1, 1'b0, 32'hDEAD);
        chk("ovf_err", {bus.wr_ack, bus.wr_err}, 2'b01);
        chk("ovf_count", bus.data_count, 16);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            chk("drain_dout", bus.dout, 32'h11 + i);
            chk("drain_ack", bus.rd_ack, 1);
        end
        chk("drain_empty", bus.empty, 1);

        cyc(1'b0, 1'b1, '0);
        chk("udf_err", {bus.rd_ack, bus.rd_err}, 2'b01);
        chk("udf_dout", bus.dout, 32'h20);
        chk("udf_count", bus.data_count, 0);

        cyc(1'b1, 1'b1, 32'h5);
        chk("rw_empty", {bus.wr_ack, bus.rd_ack, bus.rd_err}, 3'b101);
        chk("rw_empty_count", bus.data_count, 1);

        cyc(1'b0, 1'b0, '0);
        chk("idle_acks", {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 4'b0000);

        // Refill to full behind 0x5, then simultaneous read/write while full
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, DW'(32'h30 + i));
        chk("refill_full", bus.full, 1);
        cyc(1'b1, 1'b1, 32'hAA);
        chk("rw_full_dout", bus.dout, 32'h5);
        chk("rw_full_acks", {bus.wr_ack, bus.rd_ack}, 2'b11);
        chk("rw_full_count", bus.data_count, 16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);
        chk("rw_full_last", bus.dout, 32'hAA);
        chk("rw_full_empty", bus.empty, 1);

        // Wrap-around twice through the pointer range
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, DW'(32'h100 + pass * 16 + i));
            chk("wrap_count", bus.data_count, 10);
            for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, '0);
            chk("wrap_last", bus.dout, 32'h109 + pass * 16);
        end
        chk("wrap_empty", bus.data_count, 0);

        // Reset mid-stream beats a concurrent write
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, DW'(32'h200 + i));
        chk("pre_rst_count", bus.data_count, 7);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2FF);
        chk("mid_rst_count", bus.data_count, 0);
        chk("mid_rst_ack", bus.wr_ack, 0);
        chk("mid_rst_empty", bus.empty, 1);
        cyc(1'b1, 1'b0, 32'h300);
        chk("post_rst_ack", bus.wr_ack, 1);
        cyc(1'b0, 1'b1, '0);
        chk("post_rst_dout", bus.dout, 32'h300);

`ifdef FIFO_FLUSH_EN
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(32'h400 + i));
        chk("pre_flush_count", bus.data_count, 5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        chk("flush_count", bus.data_count, 0);
        chk("flush_acks", {bus.rd_ack, bus.rd_err}, 2'b00);
        chk("flush_dout", bus.dout, 32'h300);
        cyc(1'b1, 1'b1, 32'h7);
        chk("post_flush", {bus.wr_ack, bus.rd_err}, 2'b11);
`endif

        cyc(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
